gpio_bus_emu: RTL and testbench

Parametrised bus-mapped GPIO emulator with an integrated run-to-completion counter. It replaces the fixed-address, edge-clocked GPIO emulator with a fully clk-synchronous design. It sits on the 16-bit-address / 32-bit-data system bus (saddress, srd, swr, sdata_in/sdata_out) and exposes NUM_PORTS output/input port slices plus one control/status register.

---
 rtl/gpio_bus_emu.sv | 152 +++++++++++++++
 tb/tb_gpio_bus_emu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_emu.sv
// gpio_bus_emu: bus-mapped GPIO emulator with a run-to-completion counter.
// DATA[i] at BASE_ADDR+4*i, CTRL/STAT at BASE_ADDR+4*NUM_PORTS.
// Optional feature macro: GPIO_EMU_IRQ_EN (CTRL bit2 IRQ_EN, irq = done & IRQ_EN).
module gpio_bus_emu #(
  parameter logic [15:0] BASE_ADDR = 16'h1094,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CNT_INIT  = 134
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic [15:0]                 saddress,
  input  logic                        srd,
  input  logic                        swr,
  input  logic [31:0]                 sdata_in,
  output logic [31:0]                 sdata_out,
  output logic                        sack,
  input  logic [NUM_PORTS*PORT_W-1:0] gpio_in,
  input  logic                        gpio_latch,
  output logic [NUM_PORTS*PORT_W-1:0] gpio_out,
  output logic                        irq
);

  localparam logic [15:0]      CTRL_ADDR = 16'(BASE_ADDR + 4 * NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CNT_INIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              counter;
  logic                          done;
  logic                          irq_en;
  logic                          irq_en_nx;
  logic [NUM_PORTS*PORT_W-1:0]   gpio_in_s;
  logic                          srd_q, swr_q, latch_q;
  logic                          wr_det, rd_det, cap;
  logic                          port_hit, ctrl_hit;
  int unsigned                   port_idx;
  logic                          ctl_wr, ctl_clear, ctl_start, done_set;
  logic [31:0]                   port_rdata, stat_word;
  logic                          unused_ok;

  assign unused_ok = &{1'b0, sdata_in};

  // Registered copies of the level strobes for rising-edge detection
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      srd_q   <= srd;
      swr_q   <= swr;
      latch_q <= gpio_latch;
    end
  end

  // Access detection, address decode, control decode and read-data muxing
  always_comb begin
    wr_det   = swr & ~swr_q;
    // A write rising in the same cycle suppresses the read
    rd_det   = srd & ~srd_q & ~wr_det;
    cap      = gpio_latch & ~latch_q;
    port_hit = 1'b0;
    port_idx = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (saddress == 16'(BASE_ADDR + 4 * i)) begin
        port_hit = 1'b1;
        port_idx = i;
      end
    end
    ctrl_hit  = (saddress == CTRL_ADDR);
    ctl_wr    = wr_det & ctrl_hit;
    ctl_clear = ctl_wr & sdata_in[1];
    ctl_start = ctl_wr & sdata_in[0] & ~sdata_in[1];
`ifdef GPIO_EMU_IRQ_EN
    irq_en_nx = ctl_wr ? sdata_in[2] : irq_en;
`else
    irq_en_nx = 1'b0;
`endif
    done_set  = (state == RUN) && (counter == CNT_MAX) && !ctl_clear;
    port_rdata = '0;
    port_rdata[PORT_W-1:0] = gpio_in_s[port_idx*PORT_W +: PORT_W];
    stat_word = '0;
    stat_word[0] = done;
    stat_word[1] = (state == RUN);
    stat_word[2] = irq_en;
    stat_word[8 +: CNT_W] = counter;
  end

`ifdef GPIO_EMU_IRQ_EN
  // IRQ_EN control bit, rewritten on every CTRL write
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) irq_en <= 1'b0;
    else          irq_en <= irq_en_nx;
  end
`else
  assign irq_en = 1'b0;
`endif

  // Counter FSM; irq uses next-state terms so it rises on the same edge as done
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      counter <= CNT_LOAD;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= ~ctl_clear & (done | done_set) & irq_en_nx;
      if (ctl_clear) begin
        state   <= IDLE;
        counter <= CNT_LOAD;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ctl_start) state <= RUN;
          RUN: begin
            if (counter != CNT_MAX) begin
              counter <= counter + 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bus side: acknowledge, port writes, input capture and registered read data
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sdata_out <= '0;
      gpio_out  <= '0;
      sack      <= 1'b0;
      gpio_in_s <= '0;
    end else begin
      sack <= wr_det | rd_det;
      if (cap) gpio_in_s <= gpio_in;
      if (wr_det && port_hit) gpio_out[port_idx*PORT_W +: PORT_W] <= sdata_in[PORT_W-1:0];
      if (rd_det) begin
        if (port_hit)      sdata_out <= port_rdata;
        else if (ctrl_hit) sdata_out <= stat_word;
        else               sdata_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_bus_emu.sv
// Directed self-checking bench for gpio_bus_emu (default parameters).
module tb_gpio_bus_emu;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic        sack;
  logic [7:0]  gpio_in;
  logic        gpio_latch;
  logic [7:0]  gpio_out;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] q;
  logic        ack;

  always #5 clk = ~clk;

  gpio_bus_emu #(.BASE_ADDR(16'h1094), .NUM_PORTS(2), .PORT_W(4), .CNT_W(8), .CNT_INIT(134)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .sack(sack), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .irq(irq)
  );

  // Caller is at a negedge; one strobe cycle plus one idle cycle
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, output logic ak);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    ak = sack; swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] rd, output logic ak);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    rd = sdata_out; ak = sack; srd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_reset = 1'b0; srd = 1'b0; swr = 1'b0; saddress = '0; sdata_in = '0;
    gpio_in = '0; gpio_latch = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
    checks++; if (sdata_out !== 32'h0) begin errors++; $display("FAIL reset_sdata_out got=%h exp=0", sdata_out); end
    checks++; if (sack !== 1'b0) begin errors++; $display("FAIL reset_sack got=%b exp=0", sack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_8600) begin errors++; $display("FAIL reset_stat got=%h exp=00008600", q); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL reset_stat_ack got=%b exp=1", ack); end
  endtask

  task automatic test_data_write();
    bus_write(16'h1094, 32'hF5, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", ack); end
    bus_write(16'h1098, 32'hA, ack);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wr_gpio_out got=%h exp=a5", gpio_out); end
    bus_write(16'h10A0, 32'hFF, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL unmapped_wr_ack got=%b exp=1", ack); end
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL unmapped_wr_gpio got=%h exp=a5", gpio_out); end
  endtask

  task automatic test_held_strobe();
    int n = 0;
    saddress = 16'h1094; sdata_in = 32'h7; swr = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (sack === 1'b1) n++; end
    swr = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (sack === 1'b1) n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL held_swr_sacks got=%0d exp=1", n); end
    checks++; if (gpio_out !== 8'hA7) begin errors++; $display("FAIL held_swr_gpio got=%h exp=a7", gpio_out); end
  endtask

  task automatic test_latch_read();
    gpio_in = 8'h3C; gpio_latch = 1'b1;
    @(negedge clk); gpio_latch = 1'b0;
    @(negedge clk);
    bus_read(16'h1098, q, ack);
    checks++; if (q !== 32'h3) begin errors++; $display("FAIL read_port1 got=%h exp=3", q); end
    bus_read(16'h1094, q, ack);
    checks++; if (q !== 32'hC) begin errors++; $display("FAIL read_port0 got=%h exp=c", q); end
    bus_read(16'h10A0, q, ack);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", q); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL unmapped_rd_ack got=%b exp=1", ack); end
    // capture and read on the same edge: read sees the old capture
    gpio_in = 8'h5A; gpio_latch = 1'b1; saddress = 16'h1094; srd = 1'b1;
    @(negedge clk);
    q = sdata_out; srd = 1'b0; gpio_latch = 1'b0;
    @(negedge clk);
    checks++; if (q !== 32'hC) begin errors++; $display("FAIL latch_and_read got=%h exp=c", q); end
    bus_read(16'h1094, q, ack);
    checks++; if (q !== 32'hA) begin errors++; $display("FAIL read_after_latch got=%h exp=a", q); end
  endtask

  task automatic test_rd_wr_same();
    int n = 0;
    saddress = 16'h1098; sdata_in = 32'h6; swr = 1'b1; srd = 1'b1;
    @(negedge clk);
    if (sack === 1'b1) n++;
    swr = 1'b0; srd = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (sack === 1'b1) n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL rdwr_sacks got=%0d exp=1", n); end
    checks++; if (gpio_out !== 8'h67) begin errors++; $display("FAIL rdwr_gpio got=%h exp=67", gpio_out); end
    checks++; if (sdata_out !== 32'hA) begin errors++; $display("FAIL rdwr_sdata_out got=%h exp=a", sdata_out); end
  endtask

  task automatic test_counter();
    saddress = 16'h109C; sdata_in = 32'h1; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    for (int c = 1; c <= 122; c++) begin
      @(negedge clk);
      if (c == 121) begin
        checks++; if (dut.done !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", dut.done); end
      end
      if (c == 122) begin
        checks++; if (dut.done !== 1'b1) begin errors++; $display("FAIL done_at_122 got=%b exp=1", dut.done); end
      end
    end
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_FF01) begin errors++; $display("FAIL stat_done got=%h exp=0000ff01", q); end
    bus_write(16'h109C, 32'h1, ack);
    repeat (3) @(negedge clk);
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_FF01) begin errors++; $display("FAIL second_start got=%h exp=0000ff01", q); end
  endtask

  task automatic test_start_clear();
    bus_write(16'h109C, 32'h3, ack);
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_8600) begin errors++; $display("FAIL clear_from_done got=%h exp=00008600", q); end
    bus_write(16'h109C, 32'h3, ack);
    repeat (5) @(negedge clk);
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_8600) begin errors++; $display("FAIL start_clear_idle got=%h exp=00008600", q); end
  endtask

  task automatic test_clear_at_max();
    saddress = 16'h109C; sdata_in = 32'h1; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    for (int c = 1; c <= 121; c++) @(negedge clk);
    // CLEAR lands on the edge that would otherwise set done
    sdata_in = 32'h2; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    checks++; if (dut.done !== 1'b0) begin errors++; $display("FAIL clear_at_max_done got=%b exp=0", dut.done); end
    repeat (3) @(negedge clk);
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_8600) begin errors++; $display("FAIL clear_at_max_stat got=%h exp=00008600", q); end
  endtask

  task automatic test_reset_midrun();
    bus_write(16'h109C, 32'h1, ack);
    repeat (10) @(negedge clk);
    n_reset = 1'b0;
    #1;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midrun_reset_gpio got=%h exp=00", gpio_out); end
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_8600) begin errors++; $display("FAIL midrun_reset_stat got=%h exp=00008600", q); end
  endtask

  task automatic test_irq();
`ifdef GPIO_EMU_IRQ_EN
    int t = 0;
    logic prev_irq = 1'b0;
    bus_write(16'h109C, 32'h5, ack);
    while (dut.done !== 1'b1 && t < 200) begin prev_irq = irq; @(negedge clk); t++; end
    checks++; if (dut.done !== 1'b1) begin errors++; $display("FAIL irq_done_timeout got=%b exp=1", dut.done); end
    checks++; if (irq !== 1'b1 || prev_irq !== 1'b0) begin errors++; $display("FAIL irq_with_done got=%b/%b exp=0/1", prev_irq, irq); end
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_FF05) begin errors++; $display("FAIL irq_stat got=%h exp=0000ff05", q); end
    bus_write(16'h109C, 32'h2, ack);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
`else
    bus_write(16'h109C, 32'h5, ack);
    repeat (125) @(negedge clk);
    checks++; if (dut.done !== 1'b1) begin errors++; $display("FAIL noirq_done got=%b exp=1", dut.done); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL noirq_irq got=%b exp=0", irq); end
    bus_read(16'h109C, q, ack);
    checks++; if (q !== 32'h0000_FF01) begin errors++; $display("FAIL noirq_stat got=%h exp=0000ff01", q); end
    bus_write(16'h109C, 32'h2, ack);
`endif
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_held_strobe();
    test_latch_read();
    test_rd_wr_same();
    test_counter();
    test_start_clear();
    test_clear_at_max();
    test_reset_midrun();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
